beep_pattern_ctrl: RTL and testbench
====================================

BEEP_PATTERN_CTRL -- requirements
Module: beep_pattern_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter N_CH, default 4, number of trigger channels (1..16).
REQ-003 SHALL have parameter TONE0_HZ, default 2_000, tone frequency of channel 0.
REQ-004 SHALL have parameter TONE_STEP_HZ, default 500, tone increment per channel index.
REQ-005 SHALL have parameter ON_CYC, default 5_000_000, clock cycles per beep-on phase.
REQ-006 SHALL have parameter OFF_CYC, default 5_000_000, clock cycles per gap between beeps.
REQ-007 SHALL have port clk, input, 1, system clock.
REQ-008 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-009 SHALL have port trig, input, N_CH, per-channel trigger (single-cycle pulse, or level in continuous mode).
REQ-010 SHALL have port mode, input, 2, 0 = single, 1 = burst, 2 = continuous, 3 = mute.
REQ-011 SHALL have port burst_len, input, 4, beep count for burst mode.
REQ-012 SHALL have port beep, output, 1, registered buzzer drive.
REQ-013 SHALL have port busy, output, 1, high while the FSM is not IDLE.
REQ-014 SHALL have port active_ch, output, clog2(N_CH) (min 1), channel currently being played.

Function
REQ-015 Channel k SHALL use half-period HALF_k = CLK_HZ / (2*(TONE0_HZ + k*TONE_STEP_HZ)), clamped to a minimum of 1.
REQ-016 FSM SHALL have states IDLE, ON and OFF.
REQ-017 In IDLE, any nonzero trig with mode != 3 SHALL select the lowest asserted index, latch mode and burst_len (0 treated as 1), and enter ON on the next edge.
REQ-018 beep SHALL be 1 in the first ON cycle, toggle every HALF_k cycles during ON, and be 0 in IDLE and OFF.
REQ-019 ON SHALL last exactly ON_CYC cycles and OFF exactly OFF_CYC cycles.
REQ-020 Single mode: ON -> IDLE after one ON phase, with no OFF phase.
REQ-021 Burst mode: ON/OFF SHALL alternate until burst_len ON phases complete; the last ON goes to IDLE with no trailing OFF.
REQ-022 Continuous mode: ON/OFF SHALL alternate while trig[active_ch] is high.
REQ-023 Continuous mode: trig[active_ch] low SHALL force IDLE on the next edge, with beep 0 from that edge.
REQ-024 Retrigger: any nonzero trig while busy SHALL restart the pattern in ON with the lowest asserted channel and newly latched mode/burst_len.
REQ-025 Retrigger SHALL reset the phase counter, burst counter and tone phase.
REQ-026 Retrigger SHALL NOT apply in continuous mode to a trig that is only trig[active_ch] held high.
REQ-027 mode = 3 sampled at any edge SHALL abort to IDLE on that edge.
REQ-028 With mode = 3, triggers SHALL be ignored.
REQ-029 Simultaneous triggers SHALL be resolved as lowest index wins; higher-index pulses in the same cycle SHALL be discarded, not queued.
REQ-030 Counters SHALL be sized by clog2 of their maximum value and SHALL never wrap; terminal-count compares SHALL use equality to the value minus 1.
REQ-031 busy and active_ch SHALL be registered and SHALL update on the same edge as the state.

Reset
REQ-032 rst high SHALL asynchronously force IDLE, beep = 0, busy = 0, active_ch = 0 and all counters to 0.
REQ-033 Reset asserted mid-pattern SHALL silence beep immediately, with no completion of the current phase.
REQ-034 After rst release, the first trig SHALL be honoured on the first clk edge.

Structure
REQ-035 A shared package beep_pkg SHALL hold the mode encodings (MODE_SINGLE/BURST/CONT/MUTE), the state type, and the half-period constant function.
REQ-036 The tone generator SHALL be a sub-module beep_tone_gen (inputs: clk, rst, restart, half_per; output: sq).
REQ-037 beep_pattern_ctrl SHALL instantiate beep_tone_gen once, with half_per selected by active_ch.

Verification
REQ-038 The bench SHALL use CLK_HZ=1000, TONE0_HZ=100, TONE_STEP_HZ=25, ON_CYC=20, OFF_CYC=10, N_CH=4, giving HALF_0=5 and HALF_1=4.
REQ-039 Scenario single: 1-cycle pulse on trig[0], mode=0 -> beep toggles every 5 cycles for 20 cycles, busy high for 20 cycles, then IDLE.
REQ-040 Scenario burst: trig[1], mode=1, burst_len=3 -> 3 ON windows of 20 cycles with toggles every 4 cycles, 2 OFF gaps of 10 cycles, busy high for 80 cycles.
REQ-041 Scenario burst_len=0 -> behaves exactly as burst_len=1.
REQ-042 Scenario collision: trig=4'b1010 in one cycle -> active_ch=1.
REQ-043 Scenario retrigger: trig[0] pulse 12 cycles into a channel-2 ON phase -> active_ch=0, ON counter restarts, beep=1 on the next cycle.
REQ-044 Scenario continuous: trig[3] held 45 cycles in mode=2 -> ON 20, OFF 10, ON until the release edge, then IDLE with beep=0 on the next edge.
REQ-045 Scenario mute: mode=3 asserted mid-burst -> IDLE next edge.
REQ-046 Scenario mute: trig pulses while mode=3 -> busy stays 0.
REQ-047 Scenario reset: rst pulsed mid-ON, asynchronous to clk -> beep, busy and active_ch are 0 before the next clk edge.

Source files
------------

// File: rtl/beep_pkg.sv
// rtl/beep_pkg.sv - shared encodings and tone half-period helpers for the beeper
package beep_pkg;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_BURST  = 2'd1,
        MODE_CONT   = 2'd2,
        MODE_MUTE   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_e;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // Half-period in clocks of channel k's tone, never below one cycle.
    function automatic int half_period(input int clk_hz, input int tone0_hz,
                                       input int step_hz, input int k);
        int f;
        int h;
        f = tone0_hz + k * step_hz;
        if (f <= 0) return 1;
        h = clk_hz / (2 * f);
        return (h < 1) ? 1 : h;
    endfunction

    function automatic int max_half(input int clk_hz, input int tone0_hz,
                                    input int step_hz, input int n_ch);
        int m;
        m = 1;
        for (int k = 0; k < n_ch; k++) begin
            if (half_period(clk_hz, tone0_hz, step_hz, k) > m)
                m = half_period(clk_hz, tone0_hz, step_hz, k);
        end
        return m;
    endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// rtl/beep_tone_gen.sv - restartable square-wave generator with programmable half-period
module beep_tone_gen #(
    parameter int HALF_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic [HALF_W-1:0] half_per,
    output logic              sq
);

    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic              ph_q, ph_d;

    // sq is the tone level for the coming cycle, so the parent can register it
    // in the same edge that changes its state.
    always_comb begin
        cnt_d = cnt_q;
        ph_d  = ph_q;
        if (restart) begin
            cnt_d = '0;
            ph_d  = 1'b1;
        end else if (cnt_q == half_per - HALF_W'(1)) begin
            cnt_d = '0;
            ph_d  = ~ph_q;
        end else begin
            cnt_d = cnt_q + HALF_W'(1);
        end
    end

    assign sq = ph_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
        end
    end

endmodule

// File: rtl/beep_pattern_ctrl.sv
// rtl/beep_pattern_ctrl.sv - multi-channel buzzer pattern FSM (single/burst/continuous/mute)
module beep_pattern_ctrl
    import beep_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int N_CH         = 4,
    parameter int TONE0_HZ     = 2_000,
    parameter int TONE_STEP_HZ = 500,
    parameter int ON_CYC       = 5_000_000,
    parameter int OFF_CYC      = 5_000_000,
    localparam int CH_W        = clog2_min1(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] trig,
    input  logic [1:0]      mode,
    input  logic [3:0]      burst_len,
    output logic            beep,
    output logic            busy,
    output logic [CH_W-1:0] active_ch
);

    localparam int PH_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int PH_W   = clog2_min1(PH_MAX);
    localparam int HALF_W = clog2_min1(max_half(CLK_HZ, TONE0_HZ, TONE_STEP_HZ, N_CH) + 1);
    localparam int N_TBL  = 2 ** CH_W;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        bcnt_q, bcnt_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              busy_q, busy_d;
    logic              beep_q, beep_d;
    logic              restart, to_idle, tone_sq;
    logic [N_CH-1:0]   hold_mask, trig_new;
    logic [HALF_W-1:0] half_tbl [N_TBL];
    logic [HALF_W-1:0] half_per;

    for (genvar k = 0; k < N_TBL; k++) begin : g_half
        assign half_tbl[k] = HALF_W'(half_period(CLK_HZ, TONE0_HZ, TONE_STEP_HZ,
                                                 (k < N_CH) ? k : 0));
    end

    assign half_per = half_tbl[ch_q];

    function automatic logic [CH_W-1:0] lowest(input logic [N_CH-1:0] v);
        lowest = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) lowest = CH_W'(i);
        end
    endfunction

    // A continuous pattern's own held level must not look like a fresh trigger.
    assign hold_mask = (busy_q && mode_q == MODE_CONT) ? (N_CH'(1) << ch_q) : '0;
    assign trig_new  = trig & ~hold_mask;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        ph_d    = ph_q;
        ch_d    = ch_q;
        restart = 1'b0;
        to_idle = 1'b0;
        if (mode == MODE_MUTE) begin
            to_idle = 1'b1;
        end else if (trig_new != '0) begin
            state_d = ON;
            mode_d  = mode_e'(mode);
            len_d   = (burst_len == 4'd0) ? 4'd1 : burst_len;
            bcnt_d  = '0;
            ph_d    = '0;
            ch_d    = lowest(trig);
            restart = 1'b1;
        end else begin
            case (state_q)
                ON: begin
                    if (mode_q == MODE_CONT && !trig[ch_q]) begin
                        to_idle = 1'b1;
                    end else if (ph_q == PH_W'(ON_CYC - 1)) begin
                        ph_d = '0;
                        if (mode_q == MODE_SINGLE ||
                            (mode_q == MODE_BURST && bcnt_q == len_q - 4'd1)) begin
                            to_idle = 1'b1;
                        end else begin
                            state_d = OFF;
                            if (mode_q == MODE_BURST) bcnt_d = bcnt_q + 4'd1;
                        end
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                OFF: begin
                    if (mode_q == MODE_CONT && !trig[ch_q]) begin
                        to_idle = 1'b1;
                    end else if (ph_q == PH_W'(OFF_CYC - 1)) begin
                        state_d = ON;
                        ph_d    = '0;
                        restart = 1'b1;
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                default: ;
            endcase
        end
        if (to_idle) begin
            state_d = IDLE;
            ph_d    = '0;
            bcnt_d  = '0;
            ch_d    = '0;
        end
        busy_d = (state_d != IDLE);
    end

    assign beep_d = (state_d == ON) && tone_sq;

    beep_tone_gen #(
        .HALF_W (HALF_W)
    ) u_tone (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .half_per (half_per),
        .sq       (tone_sq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_SINGLE;
            len_q   <= 4'd1;
            bcnt_q  <= '0;
            ph_q    <= '0;
            ch_q    <= '0;
            busy_q  <= 1'b0;
            beep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            ph_q    <= ph_d;
            ch_q    <= ch_d;
            busy_q  <= busy_d;
            beep_q  <= beep_d;
        end
    end

    assign beep      = beep_q;
    assign busy      = busy_q;
    assign active_ch = ch_q;

endmodule

// File: tb/tb_beep_pattern_ctrl.sv
// tb/tb_beep_pattern_ctrl.sv - randomized self-checking bench for beep_pattern_ctrl
module tb_beep_pattern_ctrl;

    localparam int CLK_HZ  = 1000;
    localparam int N_CH    = 4;
    localparam int T0_HZ   = 100;
    localparam int STEP_HZ = 25;
    localparam int ON_C    = 20;
    localparam int OFF_C   = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] trig = '0;
    logic [1:0] mode = '0;
    logic [3:0] burst_len = '0;
    logic       beep, busy;
    logic [1:0] active_ch;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: pattern described by elapsed time since its start.
    bit m_act = 0;
    int m_ch = 0, m_mode = 0, m_len = 1, m_t = 0;

    beep_pattern_ctrl #(
        .CLK_HZ       (CLK_HZ),
        .N_CH         (N_CH),
        .TONE0_HZ     (T0_HZ),
        .TONE_STEP_HZ (STEP_HZ),
        .ON_CYC       (ON_C),
        .OFF_CYC      (OFF_C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .mode      (mode),
        .burst_len (burst_len),
        .beep      (beep),
        .busy      (busy),
        .active_ch (active_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int half_of(input int k);
        int h;
        h = CLK_HZ / (2 * (T0_HZ + k * STEP_HZ));
        return (h < 1) ? 1 : h;
    endfunction

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int total_len();
        if (m_mode == 0) return ON_C;
        return m_len * ON_C + (m_len - 1) * OFF_C;
    endfunction

    function automatic logic exp_beep();
        int o;
        if (!m_act) return 1'b0;
        o = m_t % (ON_C + OFF_C);
        if (o >= ON_C) return 1'b0;
        return ((o / half_of(m_ch)) % 2) == 0;
    endfunction

    task automatic model_edge(input logic [3:0] tg, input logic [1:0] md, input logic [3:0] bl);
        logic [3:0] eff;
        eff = tg;
        if (m_act && m_mode == 2) eff[m_ch] = 1'b0;
        if (md == 2'd3) begin
            m_act = 0;
        end else if (eff != 4'd0) begin
            m_act  = 1;
            m_ch   = lowest(tg);
            m_mode = md;
            m_len  = (bl == 4'd0) ? 1 : int'(bl);
            m_t    = 0;
        end else if (m_act) begin
            if (m_mode == 2 && !tg[m_ch]) begin
                m_act = 0;
            end else begin
                m_t++;
                if (m_mode != 2 && m_t >= total_len()) m_act = 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".beep"}, 32'(beep), 32'(exp_beep()));
        check({tag, ".busy"}, 32'(busy), 32'(m_act));
        check({tag, ".active_ch"}, 32'(active_ch), m_act ? m_ch : 0);
    endtask

    task automatic step(input logic [3:0] tg, input logic [1:0] md, input logic [3:0] bl);
        trig = tg;
        mode = md;
        burst_len = bl;
        @(posedge clk);
        model_edge(tg, md, bl);
        #1;
        compare_all("cyc");
    endtask

    task automatic idle(input int n, input logic [1:0] md);
        for (int i = 0; i < n; i++) step(4'd0, md, 4'd0);
    endtask

    logic [1:0] cur_mode;
    logic [3:0] lvl, pulse;
    int r;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst = 1'b0;

        // single on channel 0, honoured on the first edge after reset
        step(4'b0001, 2'd0, 4'd0);
        idle(25, 2'd0);
        // burst of 3 on channel 1
        step(4'b0010, 2'd1, 4'd3);
        idle(85, 2'd1);
        // burst_len 0 acts as 1
        step(4'b0100, 2'd1, 4'd0);
        idle(25, 2'd1);
        // collision resolves to channel 1
        step(4'b1010, 2'd0, 4'd0);
        check("collision.ch", 32'(active_ch), 32'd1);
        idle(22, 2'd0);
        // retrigger into a channel-2 ON phase
        step(4'b0100, 2'd0, 4'd0);
        idle(11, 2'd0);
        step(4'b0001, 2'd0, 4'd0);
        check("retrig.beep", 32'(beep), 32'd1);
        check("retrig.ch", 32'(active_ch), 32'd0);
        idle(22, 2'd0);
        // continuous, channel 3 held for 45 cycles
        for (int i = 0; i < 45; i++) step(4'b1000, 2'd2, 4'd0);
        step(4'b0000, 2'd2, 4'd0);
        check("cont.release", 32'(busy), 32'd0);
        idle(3, 2'd2);
        // mute mid-burst, then pulses while muted
        step(4'b0010, 2'd1, 4'd3);
        idle(30, 2'd1);
        step(4'b0000, 2'd3, 4'd0);
        check("mute.busy", 32'(busy), 32'd0);
        step(4'b0001, 2'd3, 4'd2);
        step(4'b1111, 2'd3, 4'd5);
        check("mute.ignore", 32'(busy), 32'd0);
        idle(3, 2'd0);
        // asynchronous reset mid-ON
        step(4'b0001, 2'd0, 4'd0);
        idle(5, 2'd0);
        #2 rst = 1'b1;
        #1;
        m_act = 0;
        check("arst.beep", 32'(beep), 32'd0);
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.ch", 32'(active_ch), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        compare_all("arst.hold");

        cur_mode = 2'd0;
        lvl = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                r = $urandom_range(0, 9);
                cur_mode = (r == 0) ? 2'd3 : (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : 2'd2;
            end
            if ($urandom_range(0, 49) == 0) lvl = lvl ^ (4'b0001 << $urandom_range(0, 3));
            pulse = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            step(pulse | ((cur_mode == 2'd2) ? lvl : 4'd0), cur_mode, 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
